// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stage enables, load-use bubbles, branch flushes,
// and the data-memory request/ack handshake with a sticky timeout error.
module pipe_hazard_ctrl #(
  parameter logic [4:0] OP_LOAD  = 5'b10100,
  parameter logic [4:0] OP_STORE = 5'b10101,
  parameter int         TIMEOUT  = 16,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [19:0]      ins,
  input  logic             ins_valid,
  input  logic             flush_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_bubble,
  output logic             pipe_en,
  output logic             dmem_req,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             timeout_err,
  output logic [1:0]       fsm_state
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               timeout_err_q, timeout_err_d;
  logic               acked_q, acked_d;
  logic               ex_valid_q, ex_valid_d;
  logic [4:0]         ex_op_q, ex_op_d;
  logic [4:0]         ex_rd_q, ex_rd_d;
  logic               mem_valid_q, mem_valid_d;
  logic [4:0]         mem_op_q, mem_op_d;

  logic               mem_access;
  logic               is_imm;
  logic               hazard;

  // An access already acknowledged stays in MEM for the release cycle; it must not
  // be requested again while the pipeline moves it on.
  assign mem_access = mem_valid_q & ((mem_op_q == OP_LOAD) | (mem_op_q == OP_STORE)) & ~acked_q;
  assign is_imm     = (ins[19:18] == 2'b01);
  assign hazard     = ins_valid & ex_valid_q & (ex_op_q == OP_LOAD) &
                      ((ins[9:5] == ex_rd_q) | (~is_imm & (ins[4:0] == ex_rd_q)));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    acked_d       = 1'b0;
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    pipe_en       = 1'b0;
    idex_bubble   = 1'b0;
    dmem_req      = 1'b0;

    case (state_q)
      RUN: begin
        dmem_req = mem_access;
        if (mem_access & ~dmem_ack) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else if (flush_req) begin
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          pipe_en     = 1'b1;
          idex_bubble = 1'b1;
        end else if (hazard) begin
          pipe_en     = 1'b1;
          idex_bubble = 1'b1;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          pipe_en = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_d    = RUN;
          acked_d    = 1'b1;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
          state_d       = ERR;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ERR: begin
        timeout_err_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      pipe_en     = 1'b0;
      idex_bubble = 1'b1;
      dmem_req    = 1'b0;
    end

    ex_valid_d  = ex_valid_q;
    ex_op_d     = ex_op_q;
    ex_rd_d     = ex_rd_q;
    mem_valid_d = mem_valid_q;
    mem_op_d    = mem_op_q;
    if (pipe_en) begin
      ex_valid_d  = ins_valid & ~idex_bubble;
      ex_op_d     = ins[19:15];
      ex_rd_d     = ins[14:10];
      mem_valid_d = ex_valid_q;
      mem_op_d    = ex_op_q;
    end

    stall_cnt_d = stall_cnt_q;
    if (~pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
      acked_q       <= 1'b0;
      ex_valid_q    <= 1'b0;
      ex_op_q       <= '0;
      ex_rd_q       <= '0;
      mem_valid_q   <= 1'b0;
      mem_op_q      <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      timeout_err_q <= timeout_err_d;
      acked_q       <= acked_d;
      ex_valid_q    <= ex_valid_d;
      ex_op_q       <= ex_op_d;
      ex_rd_q       <= ex_rd_d;
      mem_valid_q   <= mem_valid_d;
      mem_op_q      <= mem_op_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign timeout_err = timeout_err_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: per-cycle vectors with hand-derived expected outputs,
// checked through an expected-value queue, plus a timeout/reset sequence.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam int TOUT  = 16;
  localparam int EXP_W = 24;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [19:0]      ins = '0;
  logic             ins_valid = 1'b0;
  logic             flush_req = 1'b0;
  logic             dmem_ack = 1'b0;
  logic             pc_en, ifid_en, idex_bubble, pipe_en, dmem_req, timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       fsm_state;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .OP_LOAD (5'b10100),
    .OP_STORE(5'b10101),
    .TIMEOUT (TOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .flush_req  (flush_req),
    .dmem_ack   (dmem_ack),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .idex_bubble(idex_bubble),
    .pipe_en    (pipe_en),
    .dmem_req   (dmem_req),
    .stall_cnt  (stall_cnt),
    .timeout_err(timeout_err),
    .fsm_state  (fsm_state)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic             rst;
    logic [19:0]      ins;
    logic             vld;
    logic             flush;
    logic             ack;
    logic [EXP_W-1:0] exp;
  } vec_t;

  vec_t             vecs[$];
  logic [EXP_W-1:0] exp_q[$];
  int               checks = 0;
  int               errors = 0;

  function automatic logic [19:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  // Expected word layout: pc, ifid, bubble, pipe, req, timeout_err, state, stall_cnt
  function automatic logic [EXP_W-1:0] ex(input logic pc, input logic ifid, input logic bub,
                                          input logic pipe, input logic req, input int stall,
                                          input logic terr, input logic [1:0] st);
    return {pc, ifid, bub, pipe, req, terr, st, CNT_W'(stall)};
  endfunction

  task automatic add(input logic rst, input logic [19:0] i, input logic vld,
                     input logic flush, input logic ack, input logic [EXP_W-1:0] e);
    vec_t v;
    v.rst = rst; v.ins = i; v.vld = vld; v.flush = flush; v.ack = ack; v.exp = e;
    vecs.push_back(v);
  endtask

  // ---------------- driver + scoreboard ----------------
  task automatic apply(input vec_t v, input string name);
    logic [EXP_W-1:0] act;
    logic [EXP_W-1:0] expv;
    @(negedge clk);
    reset     = v.rst;
    ins       = v.ins;
    ins_valid = v.vld;
    flush_req = v.flush;
    dmem_ack  = v.ack;
    exp_q.push_back(v.exp);
    #2;
    act  = {pc_en, ifid_en, idex_bubble, pipe_en, dmem_req, timeout_err, fsm_state, stall_cnt};
    expv = exp_q.pop_front();
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got pc=%b ifid=%b bub=%b pipe=%b req=%b terr=%b st=%0d stall=%0d, expected pc=%b ifid=%b bub=%b pipe=%b req=%b terr=%b st=%0d stall=%0d",
               name, act[23], act[22], act[21], act[20], act[19], act[18], act[17:16], act[15:0],
               expv[23], expv[22], expv[21], expv[20], expv[19], expv[18], expv[17:16], expv[15:0]);
    end
  endtask

  logic [19:0] alu, ld5, use5, immi, st;

  initial begin
    alu  = mk(5'b00001, 5'd3, 5'd1, 5'd2);
    ld5  = mk(5'b10100, 5'd5, 5'd1, 5'd0);
    use5 = mk(5'b00010, 5'd6, 5'd5, 5'd2);
    immi = mk(5'b01000, 5'd6, 5'd7, 5'd5);
    st   = mk(5'b10101, 5'd0, 5'd1, 5'd2);

    // reset, then independent ALU traffic
    add(1, alu, 0, 0, 0, ex(0,0,1,0,0, 0, 0, S_RUN));
    add(1, alu, 0, 0, 0, ex(0,0,1,0,0, 0, 0, S_RUN));
    add(0, alu, 1, 0, 0, ex(1,1,0,1,0, 0, 0, S_RUN));
    add(0, alu, 1, 0, 0, ex(1,1,0,1,0, 0, 0, S_RUN));
    // load-use on rs1: exactly one bubble
    add(0, ld5,  1, 0, 0, ex(1,1,0,1,0, 0, 0, S_RUN));
    add(0, use5, 1, 0, 0, ex(0,0,1,1,0, 0, 0, S_RUN));
    add(0, use5, 1, 0, 1, ex(1,1,0,1,1, 1, 0, S_RUN));
    // immediate form: imm field equal to rd is not a source
    add(0, ld5,  1, 0, 0, ex(1,1,0,1,0, 1, 0, S_RUN));
    add(0, immi, 1, 0, 0, ex(1,1,0,1,0, 1, 0, S_RUN));
    add(0, alu,  1, 0, 1, ex(1,1,0,1,1, 1, 0, S_RUN));
    // store with ack on its fourth request cycle
    add(0, st,  1, 0, 0, ex(1,1,0,1,0, 1, 0, S_RUN));
    add(0, alu, 1, 0, 0, ex(1,1,0,1,0, 1, 0, S_RUN));
    add(0, alu, 1, 0, 0, ex(0,0,0,0,1, 1, 0, S_RUN));
    add(0, alu, 1, 0, 0, ex(0,0,0,0,1, 2, 0, S_WAIT));
    add(0, alu, 1, 0, 0, ex(0,0,0,0,1, 3, 0, S_WAIT));
    add(0, alu, 1, 0, 1, ex(0,0,0,0,1, 4, 0, S_WAIT));
    add(0, alu, 1, 0, 0, ex(1,1,0,1,0, 5, 0, S_RUN));
    // store with same-cycle ack
    add(0, st,  1, 0, 0, ex(1,1,0,1,0, 5, 0, S_RUN));
    add(0, alu, 1, 0, 0, ex(1,1,0,1,0, 5, 0, S_RUN));
    add(0, alu, 1, 0, 1, ex(1,1,0,1,1, 5, 0, S_RUN));
    add(0, alu, 1, 0, 0, ex(1,1,0,1,0, 5, 0, S_RUN));
    // flush beats hazard; flush during wait waits for release
    add(0, ld5,  1, 0, 0, ex(1,1,0,1,0, 5, 0, S_RUN));
    add(0, use5, 1, 1, 0, ex(1,1,1,1,0, 5, 0, S_RUN));
    add(0, alu,  1, 0, 0, ex(0,0,0,0,1, 5, 0, S_RUN));
    add(0, alu,  1, 1, 0, ex(0,0,0,0,1, 6, 0, S_WAIT));
    add(0, alu,  1, 1, 1, ex(0,0,0,0,1, 7, 0, S_WAIT));
    add(0, alu,  1, 1, 0, ex(1,1,1,1,0, 8, 0, S_RUN));
    add(0, alu,  1, 0, 0, ex(1,1,0,1,0, 8, 0, S_RUN));

    // one unchecked reset edge so every register is defined
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // timeout: load reaches MEM, no ack for TIMEOUT wait cycles
    vecs.delete();
    add(0, ld5, 1, 0, 0, ex(1,1,0,1,0, 8, 0, S_RUN));
    add(0, alu, 1, 0, 0, ex(1,1,0,1,0, 8, 0, S_RUN));
    add(0, alu, 1, 0, 0, ex(0,0,0,0,1, 8, 0, S_RUN));
    for (int k = 0; k < TOUT; k++) begin
      add(0, alu, 1, 0, 0, ex(0,0,0,0,1, 9 + k, 0, S_WAIT));
    end
    add(0, alu, 1, 0, 0, ex(0,0,0,0,0, 9 + TOUT, 1, S_ERR));
    add(0, alu, 1, 1, 1, ex(0,0,0,0,0, 10 + TOUT, 1, S_ERR));
    // reset in ERR: outputs forced at once, error cleared on the edge
    add(1, alu, 1, 0, 0, ex(0,0,1,0,0, 11 + TOUT, 1, S_ERR));
    add(0, alu, 1, 0, 0, ex(1,1,0,1,0, 0, 0, S_RUN));
    add(0, alu, 1, 0, 0, ex(1,1,0,1,0, 0, 0, S_RUN));
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("tmo%0d", i));
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
